reg_file: RTL

REG_FILE -- requirements
Module: reg_file

---
 rtl/reg_file.sv | 71 +++++++
 1 files changed

// File: rtl/reg_file.sv
// Register file with one write port, tri-state bus read, two ALU operand reads and in-place inc/dec.
// Define REG_FILE_BYPASS_EN to forward write data combinationally to reads of the address being written.
module reg_file #(
    parameter int WIDTH  = 8,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  bus_in,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [WIDTH-1:0]  bus_out,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [WIDTH-1:0]  alu_a,
    output logic [WIDTH-1:0]  alu_b,
    input  logic              inc_en,
    input  logic              dec_en,
    input  logic [ADDR_W-1:0] op_addr,
    output logic              op_zero
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [WIDTH-1:0] regs_q [DEPTH];
    logic [WIDTH-1:0] regs_d [DEPTH];
    logic [WIDTH-1:0] rd_data;

    // Inc/dec is applied first so a write to the same register overrides it.
    always_comb begin
        regs_d = regs_q;
        if (inc_en && !dec_en) begin
            regs_d[op_addr] = regs_q[op_addr] + 1'b1;
        end else if (dec_en && !inc_en) begin
            regs_d[op_addr] = regs_q[op_addr] - 1'b1;
        end
        if (wr_en) begin
            regs_d[wr_addr] = bus_in;
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            regs_q <= regs_d;
        end
    end

    always_comb begin
        rd_data = regs_q[rd_addr];
        alu_a   = regs_q[a_addr];
        alu_b   = regs_q[b_addr];
`ifdef REG_FILE_BYPASS_EN
        // Forwarding is suppressed during clear so outputs read as zero.
        if (wr_en && !clr) begin
            if (rd_addr == wr_addr) rd_data = bus_in;
            if (a_addr == wr_addr)  alu_a   = bus_in;
            if (b_addr == wr_addr)  alu_b   = bus_in;
        end
`endif
    end

    assign op_zero = (regs_q[op_addr] == '0);
    assign bus_out = rd_en ? rd_data : 'z;

endmodule
